store_data_align: RTL and testbench
===================================

Name: store_data_align

Overview:
- Store-side counterpart of the load alignment path: converts a register-file store request (SB/SH/SW) into word-aligned memory write beats with per-byte write strobes.
- Sits between the execute stage and the data memory / MMIO write port.
- Registered valid/ready handshake on both sides.
- When enabled, a misaligned store is split into two sequential beats.

Parameters:
- XLEN, `XLEN (32), data/address width; only 32 is supported.
- NSTRB, XLEN/8 (4), number of byte strobes.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  store request valid
- req_ready  out  1  block can accept a request
- req_addr  in  XLEN  byte address
- req_data  in  XLEN  rs2 store data, unshifted
- req_funct3  in  3  `FNC_SB / `FNC_SH / `FNC_SW
- mem_valid  out  1  write beat valid
- mem_ready  in  1  memory accepts beat
- mem_addr  out  XLEN  word address, bits [1:0] = 0
- mem_wdata  out  XLEN  lane-aligned write data
- mem_wstrb  out  NSTRB  byte enables, bit i = byte lane i
- busy  out  1  request in flight
- err  out  1  one-cycle pulse: illegal funct3, or misaligned store with split disabled

Behaviour:
- Reset values: state IDLE; mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, err=0, busy=0. req_ready=1 after reset.
- States: IDLE, BEAT0, BEAT1.
- req_ready is 1 exactly when state is IDLE (combinational from state).
- Request accept:
  - A request is accepted when req_valid && req_ready.
  - On the next edge the block enters BEAT0 with mem_valid=1 and registered beat-0 outputs.
  - Latency from accept to first beat on the bus: 1 cycle.
- Beat hold: mem_addr, mem_wdata and mem_wstrb stay stable while mem_valid && !mem_ready.
- Lane mapping (off = req_addr[1:0]):
  - SB: wstrb = 0001<<off; wdata = req_data[7:0] placed in lane off; other lanes 0.
  - SH, off 0..2: wstrb = 0011<<off; wdata = req_data[15:0]<<(8*off).
  - SW, off 0: wstrb = 1111; wdata = req_data.
  - Beat 0 of a split store: wstrb = (full mask<<off)[3:0]; wdata = (req_data<<(8*off))[31:0]; mem_addr = {req_addr[31:2],2'b00}.
  - Beat 1 of a split store: wstrb = the mask bits shifted out above bit 3; wdata = req_data>>(8*(4-off)); mem_addr = beat-0 address + 4, wrapping mod 2^32.
- Split condition: SH with off=3, or SW with off!=0.
- BEAT0 transitions, taken on mem_ready:
  - Split store: go to BEAT1, with mem_valid staying 1.
  - Otherwise: go to IDLE, with mem_valid=0 on the next cycle.
- BEAT1 transition: on mem_ready, go to IDLE.
- Back-to-back requests: after the final beat handshake there is one idle cycle before the next request's beat appears. No bypass.
- Illegal funct3 (anything except 000/001/010) when accepted:
  - No beat is issued; err=1 for one cycle; state stays IDLE.
- busy = (state != IDLE).
- Reset asserted mid-operation: any pending beat is dropped and all outputs go to reset values on that edge. Memory writes already handshaked are not undone.
- Simultaneous req_valid and mem_ready in BEAT0/BEAT1: the request is ignored (req_ready=0).

Optional Feature:
- Macro: MISALIGN_SPLIT_EN.
- Defined: misaligned SH/SW are split into two beats as above.
- Undefined:
  - A misaligned SH/SW is accepted but issues no beat and pulses err for one cycle.
  - BEAT1 state and its logic are not synthesized.
  - SB is always legal.

Decomposition:
- defines.v gains:
  - `NSTRB
  - state encodings `SDA_IDLE=2'd0, `SDA_BEAT0=2'd1, `SDA_BEAT1=2'd2
- Opcode.vh already supplies the FNC_SB/SH/SW codes.
- One combinational sub-module, store_lane_gen: inputs funct3, off, data; outputs beat-0/beat-1 wdata, wstrb and a split flag. It is instantiated once, and its outputs are registered on accept.

Test Plan:
- SB, addr 0x1003, data 0xAABBCC5A -> one beat; addr 0x1000, wstrb 1000, wdata[31:24]=0x5A, other lanes 0.
- SH, addr 0x2002, data 0x0000BEEF, mem_ready held low for 3 cycles -> beat stable for those cycles; then addr 0x2000, wstrb 1100, wdata 0xBEEF0000; IDLE after the handshake.
- SW, addr 0x3001, data 0x11223344 (split enabled):
  - beat0: addr 0x3000, wstrb 1110, wdata 0x22334400
  - beat1: addr 0x3004, wstrb 0001, wdata 0x00000011
- SH, addr 0xFFFFFFFF, data 0x0000A1B2:
  - beat0: addr 0xFFFFFFFC, wstrb 1000, wdata 0xB2000000
  - beat1: addr 0x00000000, wstrb 0001, wdata 0x000000A1
- funct3=3'b100 -> err pulses for 1 cycle, no mem_valid, req_ready=1 the next cycle. With MISALIGN_SPLIT_EN undefined, SW at 0x3002 -> err pulse, no beat.
- rst asserted while in BEAT1 with mem_ready=0 -> mem_valid=0, state IDLE and req_ready=1 on the next cycle.

Source files
------------

// File: rtl/store_data_align_pkg.sv
// rtl/store_data_align_pkg.sv - shared widths, store funct3 codes and FSM encodings for store_data_align
package store_data_align_pkg;

  localparam int XLEN  = 32;
  localparam int NSTRB = XLEN / 8;

  localparam logic [2:0] FNC_SB = 3'b000;
  localparam logic [2:0] FNC_SH = 3'b001;
  localparam logic [2:0] FNC_SW = 3'b010;

  localparam logic [1:0] SDA_IDLE  = 2'd0;
  localparam logic [1:0] SDA_BEAT0 = 2'd1;
  localparam logic [1:0] SDA_BEAT1 = 2'd2;

endpackage

// File: rtl/store_data_align_if.sv
// rtl/store_data_align_if.sv - store request and memory write-beat handshake bundle
interface store_data_align_if;
  import store_data_align_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [XLEN-1:0]  req_addr;
  logic [XLEN-1:0]  req_data;
  logic [2:0]       req_funct3;

  logic             mem_valid;
  logic             mem_ready;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_wdata;
  logic [NSTRB-1:0] mem_wstrb;

  modport master (
    output req_valid, req_addr, req_data, req_funct3, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_funct3, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );

endinterface

// File: rtl/store_lane_gen.sv
// rtl/store_lane_gen.sv - combinational byte-lane placement of a store into one or two word beats
module store_lane_gen
  import store_data_align_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic [1:0]       off,
  input  logic [XLEN-1:0]  data,
  output logic [XLEN-1:0]  wdata0,
  output logic [XLEN-1:0]  wdata1,
  output logic [NSTRB-1:0] wstrb0,
  output logic [NSTRB-1:0] wstrb1,
  output logic             split,
  output logic             illegal
);

  logic [NSTRB-1:0]   mask;
  logic [XLEN-1:0]    dmask;
  logic [2*NSTRB-1:0] strb_wide;
  logic [2*XLEN-1:0]  data_wide;

  // Bytes beyond the access size are zeroed so unused lanes never carry stale rs2 bits.
  always_comb begin
    mask    = '0;
    dmask   = '0;
    split   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      FNC_SB: begin
        mask  = 4'b0001;
        dmask = {24'b0, data[7:0]};
      end
      FNC_SH: begin
        mask  = 4'b0011;
        dmask = {16'b0, data[15:0]};
        split = (off == 2'd3);
      end
      FNC_SW: begin
        mask  = 4'b1111;
        dmask = data;
        split = (off != 2'd0);
      end
      default: illegal = 1'b1;
    endcase
  end

  // The upper half of each widened shift is exactly what spills into the next word.
  assign strb_wide = {{NSTRB{1'b0}}, mask} << off;
  assign data_wide = {{XLEN{1'b0}}, dmask} << {off, 3'b000};

  assign wstrb0 = strb_wide[NSTRB-1:0];
  assign wstrb1 = strb_wide[2*NSTRB-1:NSTRB];
  assign wdata0 = data_wide[XLEN-1:0];
  assign wdata1 = data_wide[2*XLEN-1:XLEN];

endmodule

// File: rtl/store_data_align.sv
// rtl/store_data_align.sv - store request to word-aligned write beats; MISALIGN_SPLIT_EN enables two-beat misaligned stores
module store_data_align
  import store_data_align_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  store_data_align_if.slave bus,
  output logic              busy,
  output logic              err
);

  logic [1:0]       state;
  logic             mem_valid_q;
  logic [XLEN-1:0]  mem_addr_q;
  logic [XLEN-1:0]  mem_wdata_q;
  logic [NSTRB-1:0] mem_wstrb_q;
  logic             err_q;

  logic [XLEN-1:0]  lg_wdata0;
  logic [XLEN-1:0]  lg_wdata1;
  logic [NSTRB-1:0] lg_wstrb0;
  logic [NSTRB-1:0] lg_wstrb1;
  logic             lg_split;
  logic             lg_illegal;
  logic             accept;
  logic             reject;

  store_lane_gen u_lane_gen (
    .funct3  (bus.req_funct3),
    .off     (bus.req_addr[1:0]),
    .data    (bus.req_data),
    .wdata0  (lg_wdata0),
    .wdata1  (lg_wdata1),
    .wstrb0  (lg_wstrb0),
    .wstrb1  (lg_wstrb1),
    .split   (lg_split),
    .illegal (lg_illegal)
  );

  assign bus.req_ready = (state == SDA_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

`ifdef MISALIGN_SPLIT_EN
  logic             split_q;
  logic [XLEN-1:0]  beat1_wdata_q;
  logic [NSTRB-1:0] beat1_wstrb_q;

  assign reject = lg_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      split_q       <= 1'b0;
      beat1_wdata_q <= '0;
      beat1_wstrb_q <= '0;
    end else if (accept) begin
      split_q       <= lg_split;
      beat1_wdata_q <= lg_wdata1;
      beat1_wstrb_q <= lg_wstrb1;
    end
  end
`else
  logic unused_beat1;

  assign reject       = lg_illegal || lg_split;
  assign unused_beat1 = ^{lg_wdata1, lg_wstrb1};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SDA_IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        SDA_IDLE: begin
          if (accept) begin
            if (reject) begin
              err_q <= 1'b1;
            end else begin
              state       <= SDA_BEAT0;
              mem_valid_q <= 1'b1;
              mem_addr_q  <= {bus.req_addr[XLEN-1:2], 2'b00};
              mem_wdata_q <= lg_wdata0;
              mem_wstrb_q <= lg_wstrb0;
            end
          end
        end
        SDA_BEAT0: begin
          if (bus.mem_ready) begin
`ifdef MISALIGN_SPLIT_EN
            if (split_q) begin
              state       <= SDA_BEAT1;
              mem_addr_q  <= mem_addr_q + 32'd4;
              mem_wdata_q <= beat1_wdata_q;
              mem_wstrb_q <= beat1_wstrb_q;
            end else
`endif
            begin
              state       <= SDA_IDLE;
              mem_valid_q <= 1'b0;
            end
          end
        end
`ifdef MISALIGN_SPLIT_EN
        SDA_BEAT1: begin
          if (bus.mem_ready) begin
            state       <= SDA_IDLE;
            mem_valid_q <= 1'b0;
          end
        end
`endif
        default: begin
          state       <= SDA_IDLE;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign busy          = (state != SDA_IDLE);
  assign err           = err_q;

endmodule

// File: tb/tb_store_data_align.sv
// tb/tb_store_data_align.sv - randomized self-checking bench for store_data_align with byte-level reference model
module tb_store_data_align;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic err;

  always #5 clk = ~clk;

  store_data_align_if bus ();

  store_data_align dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic        exp_err;
  int          exp_n;
  logic [31:0] exp_addr  [2];
  logic [31:0] exp_wdata [2];
  logic [3:0]  exp_wstrb [2];

  // Each byte of the access lands at address a+k; its word and lane decide beat and strobe.
  task automatic model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int size;
    int beat;
    logic [31:0] base;
    logic [31:0] ba;
    exp_err = 1'b0;
    exp_n   = 0;
    for (int i = 0; i < 2; i++) begin
      exp_wdata[i] = 32'h0;
      exp_wstrb[i] = 4'h0;
    end
    case (f3)
      3'b000:  size = 1;
      3'b001:  size = 2;
      3'b010:  size = 4;
      default: size = 0;
    endcase
    base        = a & 32'hFFFF_FFFC;
    exp_addr[0] = base;
    exp_addr[1] = base + 32'd4;
    if (size == 0) begin
      exp_err = 1'b1;
    end else begin
      for (int k = 0; k < size; k++) begin
        ba   = a + k;
        beat = ((ba & 32'hFFFF_FFFC) == base) ? 0 : 1;
        exp_wstrb[beat][ba[1:0]] = 1'b1;
        exp_wdata[beat][8*ba[1:0] +: 8] = d[8*k +: 8];
        if (beat + 1 > exp_n) exp_n = beat + 1;
      end
`ifndef MISALIGN_SPLIT_EN
      if (exp_n == 2) begin
        exp_err = 1'b1;
        exp_n   = 0;
      end
`endif
    end
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input int delay, input string tag);
    model(f3, a, d);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before: got %b want 1", tag, bus.req_ready);
    end
    bus.req_valid  = 1'b1;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_data   = d;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (exp_err) begin
      n_checks++;
      if ({err, bus.mem_valid, bus.req_ready, busy} !== 4'b1010) begin
        n_fail++;
        $display("FAIL %s err_pulse: got err/valid/ready/busy=%b%b%b%b want 1010",
                 tag, err, bus.mem_valid, bus.req_ready, busy);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if ({err, bus.mem_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL %s err_clear: got err/valid=%b%b want 00", tag, err, bus.mem_valid);
      end
    end else begin
      for (int b = 0; b < exp_n; b++) begin
        for (int c = 0; c <= delay; c++) begin
          n_checks++;
          if ({bus.mem_valid, busy, bus.req_ready, err} !== 4'b1100) begin
            n_fail++;
            $display("FAIL %s beat%0d ctl: got valid/busy/ready/err=%b%b%b%b want 1100",
                     tag, b, bus.mem_valid, busy, bus.req_ready, err);
          end
          n_checks++;
          if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !==
              {exp_addr[b], exp_wdata[b], exp_wstrb[b]}) begin
            n_fail++;
            $display("FAIL %s beat%0d cyc%0d: got addr=%h wdata=%h wstrb=%b want addr=%h wdata=%h wstrb=%b",
                     tag, b, c, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb,
                     exp_addr[b], exp_wdata[b], exp_wstrb[b]);
          end
          bus.mem_ready = (c == delay);
          @(posedge clk);
          #1;
          bus.mem_ready = 1'b0;
        end
      end
      n_checks++;
      if ({bus.mem_valid, busy, bus.req_ready} !== 3'b001) begin
        n_fail++;
        $display("FAIL %s done: got valid/busy/ready=%b%b%b want 001",
                 tag, bus.mem_valid, busy, bus.req_ready);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if ({bus.mem_valid, busy, err, bus.req_ready, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !==
        {4'b0001, 32'h0, 32'h0, 4'h0}) begin
      n_fail++;
      $display("FAIL %s: got valid/busy/err/ready=%b%b%b%b addr=%h wdata=%h wstrb=%b want 0001 0 0 0",
               tag, bus.mem_valid, busy, err, bus.req_ready, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lane_mapping();
    do_store(3'b000, 32'h0000_1003, 32'hAABB_CC5A, 0, "sb_lane3");
    do_store(3'b000, 32'h0000_1001, 32'hAABB_CC5A, 1, "sb_lane1");
    do_store(3'b001, 32'h0000_2002, 32'h0000_BEEF, 3, "sh_stall");
    do_store(3'b001, 32'h0000_2001, 32'h0000_1234, 0, "sh_off1");
    do_store(3'b010, 32'h0000_4000, 32'hCAFE_F00D, 2, "sw_aligned");
  endtask

  task automatic test_misaligned();
    do_store(3'b010, 32'h0000_3001, 32'h1122_3344, 0, "sw_off1");
    do_store(3'b001, 32'hFFFF_FFFF, 32'h0000_A1B2, 1, "sh_wrap");
    do_store(3'b010, 32'h0000_3002, 32'h5566_7788, 2, "sw_off2");
    do_store(3'b010, 32'h0000_3003, 32'h99AA_BBCC, 0, "sw_off3");
  endtask

  task automatic test_illegal();
    for (int f = 3; f < 8; f++) begin
      do_store(f[2:0], 32'h0000_5000 + f, 32'h0BAD_0BAD, 0, "illegal_f3");
    end
  endtask

  task automatic test_ignore_when_busy();
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0000_0041;
    bus.req_data   = 32'h0000_0012;
    @(posedge clk);
    #1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0000_0080;
    bus.req_data   = 32'hDEAD_BEEF;
    bus.mem_ready  = 1'b1;
    n_checks++;
    if ({bus.req_ready, bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !==
        {2'b01, 32'h0000_0040, 32'h0000_1200, 4'b0010}) begin
      n_fail++;
      $display("FAIL ignore_beat: got ready=%b valid=%b addr=%h wdata=%h wstrb=%b want 0 1 00000040 00001200 0010",
               bus.req_ready, bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({bus.mem_valid, busy, err} !== 3'b000) begin
        n_fail++;
        $display("FAIL ignore_after%0d: got valid/busy/err=%b%b%b want 000", i, bus.mem_valid, busy, err);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    do_store(3'b010, 32'h0000_6000, 32'h0102_0304, 0, "b2b_0");
    do_store(3'b000, 32'h0000_6006, 32'h0000_00EE, 0, "b2b_1");
    do_store(3'b001, 32'h0000_6003, 32'h0000_7788, 0, "b2b_2");
    do_store(3'b111, 32'h0000_6000, 32'h0000_0000, 0, "b2b_3");
    do_store(3'b001, 32'h0000_6000, 32'h0000_5566, 0, "b2b_4");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.req_valid  = 1'b1;
`ifdef MISALIGN_SPLIT_EN
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0000_3001;
    bus.req_data   = 32'h1122_3344;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ready = 1'b0;
    n_checks++;
    if ({bus.mem_valid, bus.mem_addr} !== {1'b1, 32'h0000_3004}) begin
      n_fail++;
      $display("FAIL rst_mid_beat1: got valid=%b addr=%h want 1 00003004", bus.mem_valid, bus.mem_addr);
    end
`else
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0000_3002;
    bus.req_data   = 32'h0000_0077;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n_checks++;
    if ({bus.mem_valid, bus.mem_addr} !== {1'b1, 32'h0000_3000}) begin
      n_fail++;
      $display("FAIL rst_mid_beat0: got valid=%b addr=%h want 1 00003000", bus.mem_valid, bus.mem_addr);
    end
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_values("rst_mid");
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus.mem_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_mid_after: got valid/busy=%b%b want 00", bus.mem_valid, busy);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    int r;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      f3 = 3'b000;
      else if (r < 6) f3 = 3'b001;
      else if (r < 9) f3 = 3'b010;
      else            f3 = 3'($urandom_range(3, 7));
      a = $urandom();
      if (i % 8 == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      d = $urandom();
      if (f3 == 3'b001) d = d & 32'h0000_FFFF;
      do_store(f3, a, d, $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_data   = 32'h0;
    bus.req_funct3 = 3'b000;
    bus.mem_ready  = 1'b0;
    test_reset();
    test_lane_mapping();
    test_misaligned();
    test_illegal();
    test_ignore_when_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
